// File: rtl/tmds_pkg.sv
// Shared types and helpers for the TMDS video scheduler: line phases,
// control-period codes and raster total calculations.
package tmds_pkg;

    typedef enum logic [2:0] {
        ACTIVE     = 3'd0,
        FPORCH     = 3'd1,
        HSYNC      = 3'd2,
        BPORCH     = 3'd3,
        PREAMBLE   = 3'd4,
        GUARD_IDLE = 3'd5
    } phase_t;

    localparam logic [1:0] CTL_VIDEO_PREAMBLE = 2'b01;
    localparam logic [1:0] CTL_IDLE           = 2'b00;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/tmds_raster_counter.sv
// Raster position counters and line phase FSM.
// Honours TMDS_HDMI_PREAMBLE_EN (preamble/guard phases before active lines).
module tmds_raster_counter
    import tmds_pkg::*;
#(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int PREAMBLE_LEN = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic [11:0] hcnt,
    output logic [10:0] vcnt,
    output phase_t      phase,
    output logic        line_active,
    output logic        vsync_on
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [11:0] H_LAST      = 12'(H_TOTAL - 1);
    localparam logic [11:0] FP_START    = 12'(H_ACTIVE);
    localparam logic [11:0] HS_START    = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] BP_START    = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] PRE_START   = 12'(H_TOTAL - 2 - PREAMBLE_LEN);
    localparam logic [11:0] GUARD_START = 12'(H_TOTAL - 2);
    localparam logic [10:0] V_LAST      = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT       = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START    = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END      = 11'(V_ACTIVE + V_FP + V_SYNC);

    phase_t      phase_nxt;
    phase_t      bp_phase;
    logic [11:0] hcnt_nxt;
    logic        pre_en;

    // Reset parks the raster at the start of the last (blanking) line.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt  <= '0;
            vcnt  <= V_LAST;
            phase <= FPORCH;
        end else begin
            hcnt  <= hcnt_nxt;
            phase <= phase_nxt;
            if (hcnt == H_LAST) begin
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 11'd1;
            end
        end
    end

    always_comb begin
        hcnt_nxt = (hcnt == H_LAST) ? '0 : hcnt + 12'd1;
`ifdef TMDS_HDMI_PREAMBLE_EN
        pre_en = (vcnt == V_LAST) || ((vcnt + 11'd1) < V_ACT);
`else
        pre_en = 1'b0;
`endif
        // Back-porch tail decode; lets HSYNC hand straight to PREAMBLE when H_BP is minimal.
        if (pre_en && hcnt_nxt >= GUARD_START) begin
            bp_phase = GUARD_IDLE;
        end else if (pre_en && hcnt_nxt >= PRE_START) begin
            bp_phase = PREAMBLE;
        end else begin
            bp_phase = BPORCH;
        end

        phase_nxt = phase;
        case (phase)
            ACTIVE:  if (hcnt_nxt == FP_START) phase_nxt = FPORCH;
            FPORCH:  if (hcnt_nxt == HS_START) phase_nxt = HSYNC;
            HSYNC:   if (hcnt_nxt == BP_START) phase_nxt = bp_phase;
            default: phase_nxt = (hcnt_nxt == '0) ? ACTIVE : bp_phase;
        endcase
    end

    assign line_active = (vcnt < V_ACT);
    assign vsync_on    = (vcnt >= VS_START) && (vcnt < VS_END);

endmodule

// File: rtl/tmds_video_scheduler.sv
// Per-pixel-clock sequencer feeding three TMDS encoders (VD/CD/VDE).
// Define TMDS_HDMI_PREAMBLE_EN for HDMI video preamble; otherwise pure DVI.
module tmds_video_scheduler
    import tmds_pkg::*;
#(
    parameter int          H_ACTIVE     = 640,
    parameter int          H_FP         = 16,
    parameter int          H_SYNC       = 96,
    parameter int          H_BP         = 48,
    parameter int          V_ACTIVE     = 480,
    parameter int          V_FP         = 10,
    parameter int          V_SYNC       = 2,
    parameter int          V_BP         = 33,
    parameter logic        HSYNC_POL    = 1'b0,
    parameter logic        VSYNC_POL    = 1'b0,
    parameter int          PREAMBLE_LEN = 8,
    parameter logic [23:0] FILL_RGB     = 24'h000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        underflow_clr,
    output logic [7:0]  vd0,
    output logic [7:0]  vd1,
    output logic [7:0]  vd2,
    output logic [1:0]  cd0,
    output logic [1:0]  cd1,
    output logic [1:0]  cd2,
    output logic        vde,
    output logic        frame_start,
    output logic        underflow
);

    if (H_BP < PREAMBLE_LEN + 2) begin : g_bp_check
        $error("H_BP (%0d) must be at least PREAMBLE_LEN+2 (%0d)", H_BP, PREAMBLE_LEN + 2);
    end

    logic [11:0] hcnt;
    logic [10:0] vcnt;
    phase_t      phase;
    logic        line_active;
    logic        vsync_on;

    tmds_raster_counter #(
        .H_ACTIVE     (H_ACTIVE),
        .H_FP         (H_FP),
        .H_SYNC       (H_SYNC),
        .H_BP         (H_BP),
        .V_ACTIVE     (V_ACTIVE),
        .V_FP         (V_FP),
        .V_SYNC       (V_SYNC),
        .V_BP         (V_BP),
        .PREAMBLE_LEN (PREAMBLE_LEN)
    ) u_raster (
        .clk         (clk),
        .rst         (rst),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .phase       (phase),
        .line_active (line_active),
        .vsync_on    (vsync_on)
    );

    logic        slot;
    logic        hsync_lvl;
    logic        vsync_lvl;
    logic [23:0] rgb;
    logic [1:0]  cd1_nxt;

    assign slot      = (phase == ACTIVE) && line_active;
    // Gated by rst so a reset cycle never consumes a pixel.
    assign pix_ready = slot && !rst;
    assign hsync_lvl = (phase == HSYNC) ? HSYNC_POL : ~HSYNC_POL;
    assign vsync_lvl = vsync_on ? VSYNC_POL : ~VSYNC_POL;
    assign rgb       = slot ? (pix_valid ? pix_data : FILL_RGB) : '0;

`ifdef TMDS_HDMI_PREAMBLE_EN
    assign cd1_nxt = (phase == PREAMBLE) ? CTL_VIDEO_PREAMBLE : CTL_IDLE;
`else
    assign cd1_nxt = CTL_IDLE;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            vd0         <= '0;
            vd1         <= '0;
            vd2         <= '0;
            cd0         <= {~VSYNC_POL, ~HSYNC_POL};
            cd1         <= CTL_IDLE;
            cd2         <= CTL_IDLE;
            vde         <= 1'b0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            vd0         <= rgb[7:0];
            vd1         <= rgb[15:8];
            vd2         <= rgb[23:16];
            cd0         <= {vsync_lvl, hsync_lvl};
            cd1         <= cd1_nxt;
            cd2         <= CTL_IDLE;
            vde         <= slot;
            frame_start <= slot && (hcnt == '0) && (vcnt == '0);
            if (slot && !pix_valid) begin
                underflow <= 1'b1;
            end else if (underflow_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule
